// File: rtl/ring_output_arbiter.sv
// ring_output_arbiter
//
// Per-output-port arbiter and two-entry staging buffer for the ring router.
// NREQ requesters compete for one outgoing packet channel. Even/odd virtual
// channels are tied to the global `polarity` phase. In each cycle the VC equal
// to `polarity` may load one packet from a requester. The opposite VC may drain
// its buffered packet downstream. Load and drain therefore never touch the
// same buffer in the same cycle.
//
// Optional feature: define RING_HOP_DEC_EN to decrement the hop field
// [55:48] at load time, saturating at 0. This is used on cw/ccw ring outputs.
// When it is undefined, packets are buffered unmodified (PE output).
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   polarity  in   global VC phase, toggles every cycle
//   req       in   [NREQ]            requester i holds a packet
//   req_data  in   [NREQ*PAC_WIDTH]  slice i = packet of requester i
//   gnt       out  [NREQ]            combinational one-hot grant (or zero)
//   out_ro    in   downstream ready
//   out_so    out  registered send strobe
//   out_do    out  [PAC_WIDTH]       registered outgoing packet
module ring_output_arbiter #(
    parameter int PAC_WIDTH = 64,
    parameter int NREQ      = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      polarity,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*PAC_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]           gnt,
    input  logic                      out_ro,
    output logic                      out_so,
    output logic [PAC_WIDTH-1:0]      out_do
);

    localparam int            PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);

    // Staging buffers and round-robin pointers, both indexed by VC.
    logic [PAC_WIDTH-1:0] stage_reg [2];
    logic [1:0]           full_reg;
    logic [PW-1:0]        ptr_reg   [2];

    logic [NREQ-1:0]      eligible;
    logic                 send_vc;
    logic [PW-1:0]        ptr_cur;
    logic                 grant_found;
    logic [PW-1:0]        grant_idx;
    logic                 load_fire;
    logic [PAC_WIDTH-1:0] grant_data;
    logic [PAC_WIDTH-1:0] load_data;
    logic [PW:0]          ptr_inc;
    logic [PW-1:0]        ptr_adv;

    // A requester may only load into the VC that is active this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_elig
            assign eligible[gi] = req[gi] &&
                (req_data[gi*PAC_WIDTH + PAC_WIDTH - 1] == polarity);
        end
    endgenerate

    assign send_vc = ~polarity;
    assign ptr_cur = ptr_reg[polarity];

    // Round-robin search upward from the active VC's pointer, with wrap.
    always_comb begin
        logic [PW:0] cand;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_cur} + (PW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!grant_found && eligible[cand[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PW-1:0];
            end
        end
    end

    // A full buffer blocks new grants on its VC until it drains.
    assign load_fire = grant_found && !full_reg[polarity];

    always_comb begin
        gnt = '0;
        if (load_fire) begin
            gnt[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                grant_data = req_data[i*PAC_WIDTH +: PAC_WIDTH];
            end
        end
    end

    always_comb begin
        load_data = grant_data;
`ifdef RING_HOP_DEC_EN
        if (grant_data[55:48] != 8'd0) begin
            load_data[55:48] = grant_data[55:48] - 8'd1;
        end
`endif
    end

    // Next pointer is one past the granted requester, modulo NREQ.
    assign ptr_inc = {1'b0, grant_idx} + (PW+1)'(1);
    assign ptr_adv = (ptr_inc == NREQ_W) ? '0 : ptr_inc[PW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_reg     <= '0;
            ptr_reg[0]   <= '0;
            ptr_reg[1]   <= '0;
            stage_reg[0] <= '0;
            stage_reg[1] <= '0;
            out_so       <= 1'b0;
            out_do       <= '0;
        end else begin
            if (load_fire) begin
                stage_reg[polarity] <= load_data;
                full_reg[polarity]  <= 1'b1;
                ptr_reg[polarity]   <= ptr_adv;
            end
            // Drain the opposite VC. A refused packet waits for that VC's next turn.
            if (full_reg[send_vc] && out_ro) begin
                out_so            <= 1'b1;
                out_do            <= stage_reg[send_vc];
                full_reg[send_vc] <= 1'b0;
            end else begin
                out_so <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ring_output_arbiter.md
# ring_output_arbiter

Per-output-port arbiter and staging buffer for the ring router. It shares one outgoing 64-bit channel (cw, ccw or pe) among NREQ input requesters, such as the two ring input buffers and the PE injection port. It enforces the even/odd virtual-channel discipline tied to `polarity`, and gives downstream a registered send/ready (`so`/`ro`) handshake. Each output channel of the router gets one instance.

## Interface
- `PAC_WIDTH`, 64: packet width. Fields: [63] vc, [62] dir, [55:48] hop, [47:0] payload.
- `NREQ`, 3: number of requesters (2..8).
- `clk`, in, 1: clock; all state updates on rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `polarity`, in, 1: global VC phase, toggles every cycle.
- `req`, in, NREQ: requester i holds a packet in `req_data` slice i.
- `req_data`, in, NREQ*PAC_WIDTH: slice i is bits [i*PAC_WIDTH +: PAC_WIDTH].
- `gnt`, out, NREQ: one-hot or zero. Combinational; packet i is consumed at the next rising edge.
- `out_ro`, in, 1: downstream ready.
- `out_so`, out, 1: registered send strobe.
- `out_do`, out, PAC_WIDTH: registered outgoing packet.

## Operation
- State:
  - Two staging buffers, `buf[0]` and `buf[1]`, indexed by VC, each with a `full` bit.
  - Two round-robin pointers, `ptr[0]` and `ptr[1]`, each log2(NREQ) bits.
- Reset (`reset`=0, asynchronous): `full`=0, `ptr`=0, `out_so`=0, `out_do`=0, and `buf` contents are 0.
- Let p = `polarity` in the current cycle.
- Load stage (VC p):
  - Requester i is eligible when `req[i]`=1 and its packet bit [63] equals p.
  - If `full[p]`=0 and at least one requester is eligible, grant the first eligible requester found searching upward from `ptr[p]` with wrap-around.
  - At the edge: `buf[p]` takes the granted packet, `full[p]` is set to 1, and `ptr[p]` becomes the granted index plus 1, modulo NREQ.
  - If `full[p]`=1, or no requester is eligible, `gnt`=0.
- Send stage (VC ~p):
  - If `full[~p]`=1 and `out_ro`=1: at the edge, `out_so` is set to 1, `out_do` takes `buf[~p]`, and `full[~p]` is cleared to 0.
  - Otherwise `out_so` is set to 0 and `out_do` holds its value.
- Load and send always act on different VCs, so they never collide. A buffer cannot be loaded and drained in the same cycle.
- The pointer for a VC advances only when that VC makes a grant. The two VCs keep independent round-robin fairness.
- A packet whose vc bit does not match p is never granted in that cycle. Requesters must hold `req` and `req_data` stable until granted.
- `dir` and payload pass through unmodified.

## Timing
- `gnt` is combinational from `req`, `req_data[63]`, `polarity`, `full` and `ptr`. There is no combinational path from `out_ro` to `gnt`.
- Latency from grant to output, with `out_ro` held at 1:
  - Grant at edge k (polarity p).
  - At edge k+1 the polarity is ~p, so the send stage drains `buf[p]`.
  - `out_so`=1 during the cycle after edge k+1. This gives 2 cycles from grant-cycle start to `out_so`.
- Per-VC throughput: one packet every 2 cycles. Aggregate throughput: one packet per cycle with alternating VCs.
- `out_so` is high for exactly one cycle per packet. `out_do` is valid only while `out_so`=1.
- Backpressure: if `out_ro`=0 in the drain cycle, `buf[~p]` stays full and is retried 2 cycles later. While the buffer is full, no new grants are made for that VC.
- Reset asserted mid-operation: buffered packets are discarded and `out_so` falls immediately (asynchronous). The first grant is possible in the first cycle after release.

## Configuration
- `RING_HOP_DEC_EN` defined:
  - At load, the hop field [55:48] is decremented by 1, saturating at 0.
  - Used on cw/ccw ring outputs.
- `RING_HOP_DEC_EN` undefined:
  - The packet is buffered unmodified.
  - Used on the PE output.

## Test plan
- Reset, then `req`=3'b001 with packet vc=0, hop=8'h01, payload 48'h1234 presented while polarity=0:
  - `gnt`=3'b001 that cycle.
  - `out_so`=1 two cycles later.
  - `out_do` shows hop=8'h00 when `RING_HOP_DEC_EN` is defined, 8'h01 when not.
- VC mismatch: packet vc=1 on requester 0 while polarity=0:
  - `gnt`=0 this cycle.
  - `gnt`=3'b001 on the next cycle (polarity=1).
- Round-robin: all 3 requesters hold vc=0 packets A, B, C with `out_ro`=1:
  - Grants are 001, 010, 100 on successive polarity-0 cycles.
  - `out_do` sequence is A, B, C.
- Backpressure: `out_ro`=0 for 6 cycles with `buf[0]` full:
  - `out_so` stays 0 and vc=0 `gnt` stays 0.
  - After `out_ro` rises, the packet is sent on the next polarity-1 edge, then vc=0 grants resume.
- Interleave: requester 0 streams vc=0 packets and requester 2 streams vc=1 packets:
  - `out_so`=1 every cycle.
  - `out_do` alternates between the two streams.
- Assert reset while both buffers are full:
  - `out_so`=0 immediately.
  - After release, no stale packet is emitted.
